// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline MEM-stage logic.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_seq_state_t;

  localparam int unsigned MEM_TIMEOUT_DEF = 15;
  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pipe_mem_seq.sv
// MEM-stage sequencer: turns EX/MEM load/store controls into a req/ack bus
// transaction and freezes the pipeline until it completes, times out or is misaligned.
module pipe_mem_seq
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mmo,
  output logic        mwreg_o,
  output logic        pipe_stall,
  output logic        err_timeout,
  output logic        err_align
);

  mem_seq_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_d, we_d, et_d, ea_d;
  logic [31:0]       addr_d, wdata_d, mmo_d;
  logic              memop;
  logic              aligned;

  assign memop   = mwmem | mm2reg;
  assign aligned = (malu[1:0] & WORD_ALIGN_MASK) == 2'b00;

  // Stall is forced low during reset so nothing upstream is frozen by a flushed op.
  assign pipe_stall = ~clrn & (((state_q == IDLE) & memop) | (state_q == REQ));
  assign mwreg_o    = ~clrn & mwreg & ~pipe_stall;

  // State and registered bus/result outputs.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mmo         <= '0;
      err_timeout <= 1'b0;
      err_align   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req     <= req_d;
      mem_we      <= we_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      mmo         <= mmo_d;
      err_timeout <= et_d;
      err_align   <= ea_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    mmo_d   = mmo;
    et_d    = err_timeout;
    ea_d    = err_align;

    case (state_q)
      IDLE: begin
        if (memop) begin
          if (aligned) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = mwmem;
            addr_d  = malu;
            wdata_d = mb;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            ea_d    = 1'b1;
            mmo_d   = '0;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!mem_we) begin
            mmo_d = mem_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          et_d    = 1'b1;
          mmo_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_mem_seq.sv
// Directed bench for pipe_mem_seq with TIMEOUT=4 and hand-computed expectations.
module tb_pipe_mem_seq;

  logic        clk;
  logic        clrn;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] mmo;
  logic        mwreg_o, pipe_stall, err_timeout, err_align;

  int n_cmp;
  int n_err;

  pipe_mem_seq #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .mwreg      (mwreg),
    .mm2reg     (mm2reg),
    .mwmem      (mwmem),
    .malu       (malu),
    .mb         (mb),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mmo        (mmo),
    .mwreg_o    (mwreg_o),
    .pipe_stall (pipe_stall),
    .err_timeout(err_timeout),
    .err_align  (err_align)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic set_op(input logic wr, input logic ld, input logic st,
                        input logic [31:0] a, input logic [31:0] d);
    mwreg  = wr;
    mm2reg = ld;
    mwmem  = st;
    malu   = a;
    mb     = d;
  endtask

  task automatic set_ack(input logic ack, input logic [31:0] rd);
    mem_ack   = ack;
    mem_rdata = rd;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clrn  = 1'b1;
    set_op(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    set_ack(1'b0, 32'h0);

    // Reset: stall and mwreg_o held low even with a pending op.
    step();
    step();
    settle();
    check_eq("rst_stall", 32'(pipe_stall), 32'd0);
    check_eq("rst_mwreg_o", 32'(mwreg_o), 32'd0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_mmo", mmo, 32'h0);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_errs", {30'd0, err_timeout, err_align}, 32'd0);
    clrn = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Load 0x100, ack in first REQ cycle.
    step();
    set_op(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    settle();
    check_eq("ld1_c0_stall", 32'(pipe_stall), 32'd1);
    check_eq("ld1_c0_mwreg_o", 32'(mwreg_o), 32'd0);
    check_eq("ld1_c0_req", 32'(mem_req), 32'd0);
    step();
    set_ack(1'b1, 32'hDEADBEEF);
    settle();
    check_eq("ld1_c1_req", 32'(mem_req), 32'd1);
    check_eq("ld1_c1_we", 32'(mem_we), 32'd0);
    check_eq("ld1_c1_addr", mem_addr, 32'h100);
    check_eq("ld1_c1_stall", 32'(pipe_stall), 32'd1);
    check_eq("ld1_c1_mwreg_o", 32'(mwreg_o), 32'd0);
    step();
    set_ack(1'b0, 32'h0);
    settle();
    check_eq("ld1_c2_req", 32'(mem_req), 32'd0);
    check_eq("ld1_c2_stall", 32'(pipe_stall), 32'd0);
    check_eq("ld1_c2_mmo", mmo, 32'hDEADBEEF);
    check_eq("ld1_c2_mwreg_o", 32'(mwreg_o), 32'd1);
    step();
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check_eq("ld1_c3_stall", 32'(pipe_stall), 32'd0);

    // Store 0x104, ack on third REQ cycle.
    set_op(1'b0, 1'b0, 1'b1, 32'h104, 32'h12345678);
    settle();
    check_eq("st_c0_stall", 32'(pipe_stall), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) set_ack(1'b1, 32'hFFFFFFFF);
      settle();
      check_eq("st_req", 32'(mem_req), 32'd1);
      check_eq("st_we", 32'(mem_we), 32'd1);
      check_eq("st_addr", mem_addr, 32'h104);
      check_eq("st_wdata", mem_wdata, 32'h12345678);
      check_eq("st_stall", 32'(pipe_stall), 32'd1);
    end
    step();
    set_ack(1'b0, 32'h0);
    settle();
    check_eq("st_done_req", 32'(mem_req), 32'd0);
    check_eq("st_done_stall", 32'(pipe_stall), 32'd0);
    check_eq("st_done_mmo", mmo, 32'hDEADBEEF);
    step();
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Load 0x200 with no ack: timeout after 4 REQ cycles.
    set_op(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    settle();
    check_eq("to_c0_stall", 32'(pipe_stall), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      step();
      check_eq("to_req", 32'(mem_req), 32'd1);
      check_eq("to_flag_early", 32'(err_timeout), 32'd0);
    end
    step();
    check_eq("to_c5_req", 32'(mem_req), 32'd0);
    check_eq("to_c5_stall", 32'(pipe_stall), 32'd0);
    check_eq("to_c5_flag", 32'(err_timeout), 32'd1);
    check_eq("to_c5_mmo", mmo, 32'h0);
    step();
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Good load afterwards; timeout flag must persist.
    set_op(1'b1, 1'b1, 1'b0, 32'h208, 32'h0);
    step();
    set_ack(1'b1, 32'hCAFEF00D);
    step();
    set_ack(1'b0, 32'h0);
    settle();
    check_eq("ld2_mmo", mmo, 32'hCAFEF00D);
    check_eq("ld2_to_sticky", 32'(err_timeout), 32'd1);
    step();
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Misaligned load 0x102.
    set_op(1'b1, 1'b1, 1'b0, 32'h102, 32'h0);
    settle();
    check_eq("al_c0_stall", 32'(pipe_stall), 32'd1);
    step();
    check_eq("al_c1_req", 32'(mem_req), 32'd0);
    check_eq("al_c1_stall", 32'(pipe_stall), 32'd0);
    check_eq("al_c1_flag", 32'(err_align), 32'd1);
    check_eq("al_c1_mmo", mmo, 32'h0);
    step();
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset on the second REQ cycle of a store.
    set_op(1'b0, 1'b0, 1'b1, 32'h300, 32'hA5A5A5A5);
    step();
    check_eq("rs_c1_req", 32'(mem_req), 32'd1);
    step();
    clrn = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check_eq("rs_c2_stall", 32'(pipe_stall), 32'd0);
    step();
    clrn = 1'b0;
    settle();
    check_eq("rs_c3_req", 32'(mem_req), 32'd0);
    check_eq("rs_c3_errs", {30'd0, err_timeout, err_align}, 32'd0);
    check_eq("rs_c3_stall", 32'(pipe_stall), 32'd0);
    check_eq("rs_c3_addr", mem_addr, 32'h0);
    set_op(1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
    step();
    check_eq("rs_ld_req", 32'(mem_req), 32'd1);
    set_ack(1'b1, 32'h0BADF00D);
    step();
    set_ack(1'b0, 32'h0);
    settle();
    check_eq("rs_ld_mmo", mmo, 32'h0BADF00D);
    check_eq("rs_ld_stall", 32'(pipe_stall), 32'd0);
    step();
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Two back-to-back loads, then an ALU op.
    set_op(1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
    step();
    check_eq("bb_a_req", 32'(mem_req), 32'd1);
    set_ack(1'b1, 32'h11111111);
    step();
    set_ack(1'b0, 32'h0);
    settle();
    check_eq("bb_a_mmo", mmo, 32'h11111111);
    check_eq("bb_gap1_req", 32'(mem_req), 32'd0);
    step();
    set_op(1'b1, 1'b1, 1'b0, 32'h504, 32'h0);
    settle();
    check_eq("bb_gap2_req", 32'(mem_req), 32'd0);
    check_eq("bb_b_c0_stall", 32'(pipe_stall), 32'd1);
    step();
    check_eq("bb_b_req", 32'(mem_req), 32'd1);
    check_eq("bb_b_addr", mem_addr, 32'h504);
    set_ack(1'b1, 32'h22222222);
    step();
    set_ack(1'b0, 32'h0);
    settle();
    check_eq("bb_b_mmo", mmo, 32'h22222222);
    check_eq("bb_b_done_stall", 32'(pipe_stall), 32'd0);
    step();
    set_op(1'b1, 1'b0, 1'b0, 32'h600, 32'h0);
    settle();
    check_eq("alu_stall", 32'(pipe_stall), 32'd0);
    check_eq("alu_mwreg_o", 32'(mwreg_o), 32'd1);
    step();
    check_eq("alu_req", 32'(mem_req), 32'd0);
    check_eq("alu_mmo", mmo, 32'h22222222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
